// File: rtl/rom_read_sequencer.sv
// Purpose : dumps a parallel ROM from address 0 to LAST_ADDR and streams each word downstream.
// Latency : out_valid rises ACCESS_CYCLES edges after start; one word per ACCESS_CYCLES+1 clocks unstalled.
// Backpressure: a word is held in HANDOFF with the ROM enables high until out_valid && out_ready.
// Optional: define ROM_SEQ_SINGLE_STEP_EN to add a `step` input and a PAUSE state between words.
module rom_read_sequencer #(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 8,
    parameter int LAST_ADDR     = 511,
    parameter int ACCESS_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
`ifdef ROM_SEQ_SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce_n,
    output logic                  rom_oe_n,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [8:0]            disp_address
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        HANDOFF = 3'd2,
`ifdef ROM_SEQ_SINGLE_STEP_EN
        PAUSE   = 3'd3,
`endif
        DONE    = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            cnt_last;
    logic            handshake;
    logic            at_last;

    assign cnt_last     = (cnt == CW'(ACCESS_CYCLES - 1));
    assign handshake    = out_valid && out_ready;
    assign at_last      = (rom_addr == ADDR_WIDTH'(LAST_ADDR));
    assign disp_address = 9'(rom_addr);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort outranks both the handshake and start
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !abort) state_next = ACCESS;
            end
            ACCESS: begin
                if (abort)         state_next = IDLE;
                else if (cnt_last) state_next = HANDOFF;
            end
            HANDOFF: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (handshake) begin
`ifdef ROM_SEQ_SINGLE_STEP_EN
                    state_next = at_last ? DONE : PAUSE;
`else
                    state_next = at_last ? DONE : ACCESS;
`endif
                end
            end
`ifdef ROM_SEQ_SINGLE_STEP_EN
            PAUSE: begin
                if (abort)     state_next = IDLE;
                else if (step) state_next = ACCESS;
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status decode: busy while a dump is in flight, done only in the DONE cycle
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ACCESS, HANDOFF: busy = 1'b1;
`ifdef ROM_SEQ_SINGLE_STEP_EN
            PAUSE:           busy = 1'b1;
`endif
            DONE:            done = 1'b1;
            default: ;
        endcase
    end

    // Registered ROM pins, access counter and output word
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr  <= '0;
            rom_ce_n  <= 1'b1;
            rom_oe_n  <= 1'b1;
            cnt       <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
        end else if (abort && state != IDLE) begin
            rom_addr  <= '0;
            rom_ce_n  <= 1'b1;
            rom_oe_n  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rom_addr <= '0;
                    if (start && !abort) begin
                        rom_ce_n <= 1'b0;
                        rom_oe_n <= 1'b0;
                        cnt      <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (cnt_last) begin
                        out_data  <= rom_data;
                        out_addr  <= rom_addr;
                        out_valid <= 1'b1;
                        rom_ce_n  <= 1'b1;
                        rom_oe_n  <= 1'b1;
                    end
                end
                HANDOFF: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (!at_last) begin
                            rom_addr <= rom_addr + 1'b1;
                            cnt      <= '0;
`ifndef ROM_SEQ_SINGLE_STEP_EN
                            rom_ce_n <= 1'b0;
                            rom_oe_n <= 1'b0;
`endif
                        end
                    end
                end
`ifdef ROM_SEQ_SINGLE_STEP_EN
                PAUSE: begin
                    if (step) begin
                        rom_ce_n <= 1'b0;
                        rom_oe_n <= 1'b0;
                        cnt      <= '0;
                    end
                end
`endif
                DONE: begin
                    rom_addr <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
